// File: rtl/pipe_skid_reg.sv
// ---------------------------------------------------------------------------
// pipe_skid_reg
//
// Two-entry elastic pipeline register (skid buffer). It moves a WIDTH-bit
// word between two pipeline stages that use valid/ready handshakes. in_ready
// comes only from registered state (and from rst), so nothing runs
// combinationally from out_ready to in_ready. This cuts the stage-to-stage
// timing paths in both directions.
//
// Optional feature macro: PIPE_SKID_REG_FLUSH_EN
//   When it is defined, a flush input exists. flush empties the buffer at
//   the next clock edge.
//
// Ports
//   clk        clock; all state updates on the rising edge
//   rst        synchronous, active-high reset
//   in_valid   upstream word present on in
//   in         upstream data word
//   in_ready   block can accept a word this cycle
//   out_valid  word present on out
//   out        downstream data word (head of the buffer)
//   out_ready  downstream accepts out this cycle
//   count      number of words held (0..2)
//   flush      discard all held words (only with PIPE_SKID_REG_FLUSH_EN)
// ---------------------------------------------------------------------------
module pipe_skid_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out,
  input  logic             out_ready,
  output logic [1:0]       count
`ifdef PIPE_SKID_REG_FLUSH_EN
  ,
  input  logic             flush
`endif
);

  // The state encoding is the number of words held.
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0]       state_reg;
  logic [1:0]       state_next;
  logic [WIDTH-1:0] main_reg;
  logic [WIDTH-1:0] skid_reg;

  logic accept;
  logic pop;
  logic load_main_in;
  logic load_main_skid;
  logic load_skid_in;
  logic flush_req;

`ifdef PIPE_SKID_REG_FLUSH_EN
  assign flush_req = flush;
`else
  assign flush_req = 1'b0;
`endif

  // in_ready depends on registered state. rst is the only other term: it
  // blocks any accept while the block is being reset.
  assign in_ready  = !rst && (state_reg != FULL);
  assign out_valid = (state_reg != EMPTY);
  assign count     = state_reg;
  assign out       = main_reg;

  assign accept = in_valid && in_ready;
  assign pop    = out_valid && out_ready;

  always_comb begin
    state_next     = state_reg;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid_in   = 1'b0;

    case (state_reg)
      EMPTY: begin
        if (accept) begin
          state_next   = ONE;
          load_main_in = 1'b1;
        end
      end
      ONE: begin
        if (accept && pop) begin
          // The new word replaces the head that is leaving.
          load_main_in = 1'b1;
        end else if (accept) begin
          // The head is stalled, so the new word goes into the skid slot.
          state_next   = FULL;
          load_skid_in = 1'b1;
        end else if (pop) begin
          state_next = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          state_next     = ONE;
          load_main_skid = 1'b1;
        end
      end
      default: begin
        state_next = EMPTY;
      end
    endcase

    // A flush drops every transfer in its cycle, including any data load.
    if (flush_req) begin
      state_next     = EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid_in   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  // Data registers are not reset. They load only on the transitions listed
  // in the state logic. out therefore keeps its last value once empty.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (load_main_in) begin
        main_reg <= in;
      end else if (load_main_skid) begin
        main_reg <= skid_reg;
      end
      if (load_skid_in) begin
        skid_reg <= in;
      end
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// ---------------------------------------------------------------------------
// tb_pipe_skid_reg
//
// Self-checking bench for pipe_skid_reg. A queue-based reference model holds
// the words that should be inside the block. Each accepted word is pushed
// onto the queue. The head is compared with out every cycle and popped when
// the downstream side takes it. Define PIPE_SKID_REG_FLUSH_EN to also
// exercise flush.
// ---------------------------------------------------------------------------
module tb_pipe_skid_reg;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] in;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out;
  logic        out_ready;
  logic [1:0]  count;
  logic        flush;

  int checks;
  int failures;

  logic [31:0] sb_q[$];
  logic [31:0] last_head;
  bit          last_head_valid;
  bit          known;

  pipe_skid_reg #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in        (in),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out       (out),
    .out_ready (out_ready),
    .count     (count)
`ifdef PIPE_SKID_REG_FLUSH_EN
    ,
    .flush     (flush)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Run one clock cycle. Inputs are driven on the falling edge and outputs
  // are sampled 1 ns later. The model is then updated to match the coming
  // rising edge.
  task automatic cycle(input logic iv, input logic [31:0] d, input logic ordy,
                       input logic r, input logic f);
    bit acc;
    bit pp;
    @(negedge clk);
    in_valid  = iv;
    in        = d;
    out_ready = ordy;
    rst       = r;
    flush     = f;
    #1;
    check_value("in_ready", {31'b0, in_ready},
                {31'b0, (!r && sb_q.size() < 2)});
    if (known) begin
      check_value("out_valid", {31'b0, out_valid}, {31'b0, (sb_q.size() != 0)});
      check_value("count", {30'b0, count}, sb_q.size());
      if (sb_q.size() != 0)
        check_value("out_head", out, sb_q[0]);
      else if (last_head_valid)
        check_value("out_hold", out, last_head);
    end
    acc = known && iv && !r && (sb_q.size() < 2);
    pp  = known && ordy && (sb_q.size() != 0);
    if (r) begin
      sb_q.delete();
      known = 1'b1;
    end else if (f) begin
      sb_q.delete();
    end else begin
      if (pp) begin
        $display("pop  data=%h count_before=%0d", sb_q[0], sb_q.size());
        void'(sb_q.pop_front());
      end
      if (acc) sb_q.push_back(d);
    end
    if (sb_q.size() != 0) begin
      last_head       = sb_q[0];
      last_head_valid = 1'b1;
    end
  endtask

  initial begin
    checks          = 0;
    failures        = 0;
    known           = 1'b0;
    last_head       = '0;
    last_head_valid = 1'b0;
    in_valid        = 1'b0;
    in              = '0;
    out_ready       = 1'b0;
    rst             = 1'b1;
    flush           = 1'b0;

    // Reset held for two cycles with in_valid high: in_ready must stay low.
    cycle(1'b1, 32'hA5A5A5A5, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 32'hA5A5A5A5, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);   // checks the post-reset state

    // Single word.
    cycle(1'b1, 32'hBABEFACE, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Backpressure: fill to FULL, change in while the block is not ready,
    // then drain.
    cycle(1'b1, 32'hBABEFACE, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h12345678, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h87654321, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Streaming 0..15 with out_ready held high.
    for (int i = 0; i < 16; i++) cycle(1'b1, i, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Random valid/ready over 1000 cycles, then drain.
    for (int i = 0; i < 1000; i++)
      cycle($urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 2) != 0,
            1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Reset mid-operation drops the held words.
    cycle(1'b1, 32'hCAFE0001, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'hCAFE0002, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

`ifdef PIPE_SKID_REG_FLUSH_EN
    // Flush from FULL while a new word is offered.
    cycle(1'b1, 32'h11111111, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h22222222, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h33333333, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    // Flush in ONE together with accept and pop.
    cycle(1'b1, 32'h44444444, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h55555555, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
